// File: rtl/dmem_sized.sv
// rtl/dmem_sized.sv - byte-addressed big-endian data RAM with RISC-V sized loads/stores
// Registered read path, one request per cycle, err flags misaligned/out-of-range/illegal requests.
module dmem_sized #(
    parameter int DEPTH_BYTES = 2048,
    parameter int ADDR_WIDTH  = 64,
    parameter bit INIT_IMAGE  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] endereco,
    input  logic [63:0]           write_data,
    output logic                  resp_valid,
    output logic [63:0]           read_data,
    output logic                  err
);
    localparam int AW = $clog2(DEPTH_BYTES);

    typedef logic [7:0] mem_t [DEPTH_BYTES];

    function automatic mem_t init_image();
        mem_t m;
        for (int i = 0; i < DEPTH_BYTES; i++) begin
            m[i] = 8'd0;
            if (INIT_IMAGE && i == 7)  m[i] = 8'd8;
            if (INIT_IMAGE && i == 15) m[i] = 8'd7;
        end
        return m;
    endfunction

    // Power-up contents only; reset deliberately leaves the array alone.
    mem_t mem_q = init_image();

    logic        resp_valid_q, resp_valid_d;
    logic [63:0] read_data_q, read_data_d;
    logic        err_q, err_d;

    logic [3:0]    size_n;
    logic [2:0]    align_mask;
    logic          accept, access, bad, in_range, misaligned, illegal;
    logic [AW-1:0] idx;
    logic [63:0]   raw, ext;
    logic          wr_en   [8];
    logic [7:0]    wr_byte [8];

    assign req_ready = rst_n;

    always_comb begin
        size_n     = 4'd1;
        align_mask = 3'b000;
        case (funct3[1:0])
            2'b00: begin size_n = 4'd1; align_mask = 3'b000; end
            2'b01: begin size_n = 4'd2; align_mask = 3'b001; end
            2'b10: begin size_n = 4'd4; align_mask = 3'b011; end
            default: begin size_n = 4'd8; align_mask = 3'b111; end
        endcase

        accept     = req_valid && req_ready;
        access     = accept && (mem_read || mem_write);
        // Range check in ADDR_WIDTH+1 bits so the top of the address space cannot wrap.
        in_range   = ({1'b0, endereco} + (ADDR_WIDTH+1)'(size_n)) <= (ADDR_WIDTH+1)'(DEPTH_BYTES);
        misaligned = (endereco[2:0] & align_mask) != 3'b000;
        illegal    = (funct3 == 3'b111) || (mem_read && mem_write) || (mem_write && funct3[2]);
        bad        = misaligned || !in_range || illegal;
        idx        = endereco[AW-1:0];

        raw = 64'd0;
        for (int k = 0; k < 8; k++) begin
            if (k < int'(size_n)) raw = {raw[55:0], mem_q[idx + AW'(k)]};
        end

        ext = raw;
        case (funct3[1:0])
            2'b00:   ext = funct3[2] ? {56'd0, raw[7:0]}  : {{56{raw[7]}}, raw[7:0]};
            2'b01:   ext = funct3[2] ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            2'b10:   ext = funct3[2] ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            default: ext = raw;
        endcase

        // Byte at the lowest address takes the most significant byte of the field.
        for (int j = 0; j < 8; j++) begin
            wr_en[j]   = 1'b0;
            wr_byte[j] = 8'd0;
            if (access && mem_write && !bad && (j < int'(size_n))) begin
                wr_en[j]   = 1'b1;
                wr_byte[j] = write_data[8*(int'(size_n)-1-j) +: 8];
            end
        end

        resp_valid_d = access;
        read_data_d  = read_data_q;
        err_d        = err_q;
        if (access) begin
            err_d       = bad;
            read_data_d = (!bad && mem_read) ? ext : 64'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            read_data_q  <= 64'd0;
            err_q        <= 1'b0;
        end else begin
            resp_valid_q <= resp_valid_d;
            read_data_q  <= read_data_d;
            err_q        <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < 8; j++) begin
            if (wr_en[j]) mem_q[idx + AW'(j)] <= wr_byte[j];
        end
    end

    assign resp_valid = resp_valid_q;
    assign read_data  = read_data_q;
    assign err        = err_q;
endmodule
